// File: rtl/eu_way0_pkg.sv
// Shared types for the way0 execution-unit dispatch path.
package eu_way0_pkg;

  localparam int EU_PKT_W = 253;

  typedef struct packed {
    logic [4:0]  rdAddr;
    logic        rdWriteEnable;
    logic [31:0] instAddr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  shamt;
  } eu_pkt_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/eu_dispatch_way0_if.sv
// Decode-side and EU-side buses of the way0 dispatcher.
// Decode side: a packet transfers on a clock edge where dec_valid_i && dec_ready_o.
// EU side: valid_o is a transfer strobe; the EU captures on every cycle it is high.
import eu_way0_pkg::*;

interface eu_dispatch_way0_if #(parameter int PID_W = 2);
  logic             dec_valid_i;
  logic             dec_ready_o;
  eu_pkt_t          dec_pkt_i;
  logic             valid_o;
  logic             ready_i;
  logic [4:0]       rdAddr_o;
  logic             rdWriteEnable_o;
  logic [31:0]      instAddr_o;
  logic [63:0]      rs1ReadData_o;
  logic [63:0]      rs2ReadData_o;
  logic [63:0]      imm_o;
  logic [6:0]       opCode_o;
  logic [2:0]       funct3_o;
  logic [6:0]       funct7_o;
  logic [5:0]       shamt_o;
  logic [PID_W-1:0] way0_pID_o;

  modport master (
    input  dec_valid_i, dec_pkt_i, ready_i,
    output dec_ready_o, valid_o, rdAddr_o, rdWriteEnable_o, instAddr_o,
           rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o,
           funct7_o, shamt_o, way0_pID_o
  );

  modport slave (
    output dec_valid_i, dec_pkt_i, ready_i,
    input  dec_ready_o, valid_o, rdAddr_o, rdWriteEnable_o, instAddr_o,
           rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o,
           funct7_o, shamt_o, way0_pID_o
  );
endinterface

// File: rtl/eu_skid_buf2.sv
// Generic 2-entry in-order skid buffer; entry 0 is always the head.
import eu_way0_pkg::*;

module eu_skid_buf2 #(
  parameter type T = logic
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  T            din_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic        ready_o,
  output T            head_o,
  output skid_state_e state_o
);

  skid_state_e state_q, state_d;
  T            e0_q, e0_d, e1_q, e1_d;
  logic        ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: if (push_i) begin
          e0_d    = din_i;
          state_d = SKID_ONE;
        end
        SKID_ONE: begin
          if (push_i && !pop_i) begin
            e1_d    = din_i;
            state_d = SKID_FULL;
          end else if (!push_i && pop_i) begin
            state_d = SKID_EMPTY;
          end else if (push_i && pop_i) begin
            e0_d = din_i;
          end
        end
        // ready_o is low while full, so a push cannot arrive here
        SKID_FULL: if (pop_i) begin
          e0_d    = e1_q;
          state_d = SKID_ONE;
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    ready_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SKID_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign head_o  = e0_q;
  assign state_o = state_q;

endmodule

// File: rtl/eu_dispatch_way0.sv
// Way0 EU dispatcher: skid buffer, credit-throttled dispatch strobe, rolling packet IDs.
import eu_way0_pkg::*;

module eu_dispatch_way0 #(
  parameter int MAX_INFLIGHT = 4,
  parameter int PID_W        = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  eu_dispatch_way0_if.master  bus,
  input  logic                retire_i,
  input  logic                jumpFlag_i,
  output logic [2:0]          inflight_o,
  output logic                err_o,
  output skid_state_e         skid_state_o
);

  localparam logic [2:0] MAX_C = 3'(MAX_INFLIGHT);

  eu_pkt_t     head;
  skid_state_e skid_state;
  logic        skid_ready;
  logic        enq, fire;

  logic [2:0]       inflight_q, inflight_d;
  logic [PID_W-1:0] pid_q, pid_d;
  logic             err_q, err_d;

  // The EU register captures whenever valid_o is high, so every high cycle is a pop
  assign fire = (skid_state != SKID_EMPTY) && bus.ready_i &&
                (inflight_q < MAX_C) && !jumpFlag_i;
  assign enq  = bus.dec_valid_i && skid_ready && !jumpFlag_i;

  eu_skid_buf2 #(.T(eu_pkt_t)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (enq),
    .din_i   (bus.dec_pkt_i),
    .pop_i   (fire),
    .flush_i (jumpFlag_i),
    .ready_o (skid_ready),
    .head_o  (head),
    .state_o (skid_state)
  );

  always_comb begin
    inflight_d = inflight_q;
    pid_d      = pid_q;
    err_d      = err_q;
    if (fire) pid_d = pid_q + PID_W'(1);
    if (fire && !retire_i) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!fire && retire_i) begin
      if (inflight_q == 3'd0) err_d = 1'b1;
      else                    inflight_d = inflight_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      pid_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      pid_q      <= pid_d;
      err_q      <= err_d;
    end
  end

  assign bus.dec_ready_o     = skid_ready;
  assign bus.valid_o         = fire;
  assign bus.rdAddr_o        = head.rdAddr;
  assign bus.rdWriteEnable_o = head.rdWriteEnable;
  assign bus.instAddr_o      = head.instAddr;
  assign bus.rs1ReadData_o   = head.rs1;
  assign bus.rs2ReadData_o   = head.rs2;
  assign bus.imm_o           = head.imm;
  assign bus.opCode_o        = head.opCode;
  assign bus.funct3_o        = head.funct3;
  assign bus.funct7_o        = head.funct7;
  assign bus.shamt_o         = head.shamt;
  assign bus.way0_pID_o      = pid_q;
  assign inflight_o          = inflight_q;
  assign err_o               = err_q;
  assign skid_state_o        = skid_state;

endmodule

// File: tb/tb_eu_dispatch_way0.sv
// Bench for eu_dispatch_way0: queue-based reference model plus directed and random traffic.
import eu_way0_pkg::*;

module tb_eu_dispatch_way0;
  localparam int MAX_INFLIGHT = 4;
  localparam int PID_W        = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        retire_i = 1'b0;
  logic        jumpFlag_i = 1'b0;
  logic [2:0]  inflight_o;
  logic        err_o;
  skid_state_e skid_state_o;

  always #5 clk = ~clk;

  eu_dispatch_way0_if #(.PID_W(PID_W)) bus ();

  eu_dispatch_way0 #(.MAX_INFLIGHT(MAX_INFLIGHT), .PID_W(PID_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .retire_i     (retire_i),
    .jumpFlag_i   (jumpFlag_i),
    .inflight_o   (inflight_o),
    .err_o        (err_o),
    .skid_state_o (skid_state_o)
  );

  // reference model
  eu_pkt_t exp_q[$];
  int      m_infl, m_pid;
  bit      m_err, m_acc, m_fire;
  bit      prev_stall;
  eu_pkt_t prev_pkt;

  int total = 0, bad = 0;

  // snapshot of the last sampled cycle
  bit       last_valid, last_ready, last_err;
  int       last_infl, last_pid;
  eu_pkt_t  last_pkt;

  task automatic chk(input string name, input logic [252:0] act, input logic [252:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic eu_pkt_t rand_pkt();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return eu_pkt_t'(r[252:0]);
  endfunction

  function automatic eu_pkt_t mk(input logic [31:0] addr, input logic [4:0] rd);
    eu_pkt_t p;
    p = rand_pkt();
    p.instAddr = addr;
    p.rdAddr   = rd;
    return p;
  endfunction

  function automatic eu_pkt_t dut_pkt();
    return eu_pkt_t'({bus.rdAddr_o, bus.rdWriteEnable_o, bus.instAddr_o, bus.rs1ReadData_o,
                      bus.rs2ReadData_o, bus.imm_o, bus.opCode_o, bus.funct3_o,
                      bus.funct7_o, bus.shamt_o});
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_infl = 0; m_pid = 0; m_err = 0; prev_stall = 0;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model.
  task automatic step(input bit dv, input eu_pkt_t p, input bit rdy, input bit ret, input bit jmp);
    bit exp_ready, exp_valid;
    bus.dec_valid_i = dv; bus.dec_pkt_i = p; bus.ready_i = rdy;
    retire_i = ret; jumpFlag_i = jmp;
    if (prev_stall && dv && (p !== prev_pkt)) begin
      total++; bad++;
      $display("FAIL pkt_hold: got %0h want %0h", p, prev_pkt);
    end
    @(negedge clk);
    exp_ready = (exp_q.size() < 2);
    exp_valid = (exp_q.size() > 0) && rdy && (m_infl < MAX_INFLIGHT) && !jmp;
    chk("dec_ready", bus.dec_ready_o, exp_ready);
    chk("valid", bus.valid_o, exp_valid);
    chk("inflight", inflight_o, m_infl);
    chk("err", err_o, m_err);
    if (exp_valid) begin
      chk("pid", bus.way0_pID_o, m_pid);
      chk("pkt", dut_pkt(), exp_q[0]);
    end
    last_valid = bus.valid_o; last_ready = bus.dec_ready_o; last_err = err_o;
    last_infl = int'(inflight_o); last_pid = int'(bus.way0_pID_o); last_pkt = dut_pkt();
    m_acc  = dv && exp_ready && !jmp;
    m_fire = exp_valid;
    if (m_fire) begin
      void'(exp_q.pop_front());
      m_pid = (m_pid + 1) % (1 << PID_W);
    end
    if (m_fire && !ret) m_infl++;
    else if (!m_fire && ret) begin
      if (m_infl == 0) m_err = 1;
      else m_infl--;
    end
    if (jmp) exp_q.delete();
    if (m_acc) exp_q.push_back(p);
    prev_stall = dv && !exp_ready;
    prev_pkt   = p;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.dec_valid_i = 0; bus.dec_pkt_i = '0; bus.ready_i = 1;
    retire_i = 0; jumpFlag_i = 0;
    reset_n = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  eu_pkt_t pk[6];
  eu_pkt_t idle_p;
  int      sent, got, max_infl;
  int      pids[$];
  logic [31:0] addrs[$];
  bit [3:0] hist;

  initial begin
    idle_p = '0;
    do_reset();
    chk("rst_ready", bus.dec_ready_o, 1);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_infl", inflight_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_pid", bus.way0_pID_o, 0);
    chk("rst_state", skid_state_o, SKID_EMPTY);

    // single instruction
    pk[0] = mk(32'h8000_0000, 5'd5);
    step(1, pk[0], 1, 0, 0);
    chk("t1_acc_valid", last_valid, 0);
    step(0, idle_p, 1, 0, 0);
    chk("t1_valid", last_valid, 1);
    chk("t1_pid", last_pid, 0);
    chk("t1_addr", last_pkt.instAddr, 32'h8000_0000);
    chk("t1_rd", last_pkt.rdAddr, 5);
    step(0, idle_p, 1, 0, 0);
    chk("t1_once", last_valid, 0);
    chk("t1_infl", last_infl, 1);

    // back-to-back stream of 6 with delayed retires
    do_reset();
    for (int i = 0; i < 6; i++) pk[i] = mk(32'h1000 + i, 5'(i));
    sent = 0; hist = '0; max_infl = 0;
    pids.delete(); addrs.delete();
    for (int c = 0; c < 16; c++) begin
      step(sent < 6, pk[sent < 6 ? sent : 5], 1, hist[1], 0);
      hist = {hist[2:0], m_fire};
      if (m_acc) sent++;
      if (last_valid) begin pids.push_back(last_pid); addrs.push_back(last_pkt.instAddr); end
      if (last_infl > max_infl) max_infl = last_infl;
    end
    chk("t2_count", pids.size(), 6);
    chk("t2_max_infl", max_infl, 2);
    for (int i = 0; i < 6 && i < pids.size(); i++) begin
      chk("t2_pid", pids[i], i % 4);
      chk("t2_order", addrs[i], 32'h1000 + i);
    end

    // stall with ready_i low, then drain
    do_reset();
    for (int i = 0; i < 3; i++) pk[i] = mk(32'h2000 + i, 5'(i + 1));
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      step(1, pk[sent < 3 ? sent : 2], 0, 0, 0);
      if (m_acc) sent++;
    end
    chk("t3_accepted", sent, 2);
    chk("t3_ready_low", last_ready, 0);
    chk("t3_valid_low", last_valid, 0);
    chk("t3_state", skid_state_o, SKID_FULL);
    addrs.delete();
    for (int c = 0; c < 10; c++) begin
      step(sent < 3, pk[sent < 3 ? sent : 2], 1, 0, 0);
      if (m_acc) sent++;
      if (last_valid) addrs.push_back(last_pkt.instAddr);
    end
    chk("t3_count", addrs.size(), 3);
    for (int i = 0; i < 3 && i < addrs.size(); i++) chk("t3_order", addrs[i], 32'h2000 + i);

    // credit limit
    do_reset();
    for (int i = 0; i < 5; i++) pk[i] = mk(32'h3000 + i, 5'(i));
    sent = 0; got = 0;
    for (int c = 0; c < 12; c++) begin
      step(sent < 5, pk[sent < 5 ? sent : 4], 1, 0, 0);
      if (m_acc) sent++;
      if (last_valid) got++;
    end
    chk("t4_disp", got, 4);
    chk("t4_infl", last_infl, 4);
    chk("t4_held", last_valid, 0);
    step(0, idle_p, 1, 1, 0);
    chk("t4_ret_cycle", last_valid, 0);
    step(0, idle_p, 1, 0, 0);
    chk("t4_fifth", last_valid, 1);
    chk("t4_fifth_addr", last_pkt.instAddr, 32'h3004);

    // flush while full
    do_reset();
    for (int i = 0; i < 4; i++) pk[i] = mk(32'h4000 + i, 5'(i));
    step(1, pk[0], 0, 0, 0);
    step(1, pk[1], 0, 0, 0);
    step(1, pk[2], 0, 0, 0);
    chk("t5_full", skid_state_o, SKID_FULL);
    step(1, pk[2], 1, 0, 1);
    chk("t5_jmp_valid", last_valid, 0);
    chk("t5_empty", skid_state_o, SKID_EMPTY);
    step(0, idle_p, 1, 0, 0);
    chk("t5_ready", last_ready, 1);
    chk("t5_no_enq", last_valid, 0);
    step(1, pk[3], 1, 0, 0);
    step(0, idle_p, 1, 0, 0);
    chk("t5_new", last_pkt.instAddr, 32'h4003);
    chk("t5_pid", last_pid, 0);

    // retire underflow, then async reset
    do_reset();
    step(0, idle_p, 1, 1, 0);
    chk("t6_err_pre", last_err, 0);
    step(0, idle_p, 1, 0, 0);
    chk("t6_err", last_err, 1);
    chk("t6_infl", last_infl, 0);
    for (int c = 0; c < 3; c++) step(0, idle_p, 1, 0, 0);
    chk("t6_err_hold", last_err, 1);
    step(1, pk[0], 0, 0, 0);
    bus.dec_valid_i = 0; bus.ready_i = 1;
    #2;
    chk("t6_pre_valid", bus.valid_o, 1);
    reset_n = 0;
    #1;
    chk("t6_arst_valid", bus.valid_o, 0);
    chk("t6_arst_ready", bus.dec_ready_o, 1);
    chk("t6_arst_err", err_o, 0);
    chk("t6_arst_infl", inflight_o, 0);
    chk("t6_arst_pid", bus.way0_pID_o, 0);
    do_reset();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      eu_pkt_t p;
      bit dv, rdy, ret, jmp;
      if (prev_stall) begin dv = 1; p = prev_pkt; end
      else begin dv = ($urandom_range(0, 3) != 0); p = rand_pkt(); end
      rdy = ($urandom_range(0, 3) != 0);
      ret = (m_infl > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      jmp = ($urandom_range(0, 30) == 0);
      step(dv, p, rdy, ret, jmp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
